ascon_fsm_param: RTL and testbench
==================================

// Module: ascon_fsm_param
// PURPOSE
//  Parametrised ASCON-128 AEAD control FSM with internal round counter; drives the datapath that holds the 320-bit state.
//  Processes any number of AD blocks (including zero) and plaintext blocks using a valid/ready/last handshake.
//  Round counts are parameters, so the same block serves ASCON-128 (12/6) and reduced-round test builds.
// PARAMETERS
//  ROUNDS_A  12  rounds of p^a (init, finalisation); 1..12
//  ROUNDS_B  6   rounds of p^b (AD, non-last PT blocks); 1..ROUNDS_A
//  BLK_W     8   width of accepted-block counter
// PORTS
//  clock_i            in   1      single clock, rising edge
//  reset_i            in   1      synchronous, active-high
//  start_i            in   1      start request; sampled only in IDLE
//  ad_present_i       in   1      sampled with start_i; 0 = empty AD
//  data_valid_i       in   1      data block offered
//  last_i             in   1      qualifies data_valid_i: last block of current phase
//  ready_o            out  1      FSM can accept a block (wait states)
//  round_o            out  4      round-constant index to permutation
//  init_state_o       out  1      load IV||K||N into state register
//  en_reg_state_o     out  1      state register update enable
//  en_xor_data_o      out  1      XOR data block into rate before round
//  en_xor_begin_key_o out  1      XOR 0^64||K before round
//  en_xor_end_key_o   out  1      XOR 0*||K after round
//  en_xor_lsb_o       out  1      XOR domain-separation bit after round
//  en_cipher_o        out  1      capture ciphertext register
//  cipher_valid_o     out  1      ciphertext register valid, 1-cycle pulse
//  en_tag_o           out  1      capture tag register
//  end_init_o         out  1      1-cycle pulse, init done
//  end_associate_o    out  1      1-cycle pulse, AD phase done
//  end_o              out  1      1-cycle pulse, tag valid
//  blk_cnt_o          out  BLK_W  blocks accepted since start, saturating
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, every output 0. reset_i wins over all inputs, including mid-permutation.
//  - States: IDLE, INIT, AD_WAIT, AD_RUN, PT_WAIT, PT_RUN, FINAL, DONE.
//  - Accept = data_valid_i & ready_o; ready_o=1 only in AD_WAIT/PT_WAIT. Blocks offered outside these states are ignored.
//  - IDLE: start_i=1 -> INIT; latch ad_present_i; clear blk_cnt_o. Otherwise stay.
//  - INIT: ROUNDS_A cycles; round_o = 12-ROUNDS_A+k (k=0..). First cycle: init_state_o=1.
//    All cycles: en_reg_state_o=1. Last cycle: en_xor_end_key_o=1, plus en_xor_lsb_o=1 if ad_present=0.
//    Exit -> AD_WAIT if ad_present, else PT_WAIT. end_init_o pulses in the first cycle of the next state.
//  - AD_WAIT: on accept -> AD_RUN, latch last_i.
//  - AD_RUN: ROUNDS_B cycles, round_o = 12-ROUNDS_B+k; first cycle en_xor_data_o=1.
//    Last cycle: if latched last, en_xor_lsb_o=1 -> PT_WAIT with end_associate_o pulse; else -> AD_WAIT.
//  - PT_WAIT: accept, last_i=0 -> PT_RUN; accept, last_i=1 -> FINAL.
//  - PT_RUN: ROUNDS_B cycles; first cycle en_xor_data_o=en_cipher_o=1 -> PT_WAIT.
//  - FINAL: ROUNDS_A cycles; first cycle en_xor_data_o=en_cipher_o=en_xor_begin_key_o=1.
//    Last cycle: en_xor_end_key_o=en_tag_o=1 -> DONE.
//  - cipher_valid_o pulses the cycle after each en_cipher_o.
//  - DONE: end_o=1 for one cycle -> IDLE. start_i in DONE is ignored.
//  - Round counter resets to 0 on every RUN/INIT/FINAL entry. round_o=0 outside permutation states.
//  - blk_cnt_o increments on each accept and saturates at 2^BLK_W-1.
//  - last_i with data_valid_i=0 is ignored. Simultaneous start_i during any non-IDLE state is ignored.
// CONFIGURATION
//  ASCON_DECRYPT_EN defined:
//   - adds input decrypt_i (sampled with start_i) and output en_replace_o.
//   - In decrypt, PT_RUN/FINAL first cycle asserts en_replace_o instead of en_xor_data_o (rate overwritten by ciphertext).
//   - en_cipher_o is unchanged.
//  Undefined: decrypt_i and en_replace_o are absent; encrypt only.
// TESTING
//  - reset_i=1 mid-INIT (round_o=5) -> next cycle IDLE, all outputs 0, ready_o=0.
//  - Default params, start@c0, ad_present=1 -> INIT c1..c12 with round_o 0..11; en_xor_end_key_o@c12; end_init_o@c13.
//  - ad_present=0 -> en_xor_end_key_o and en_xor_lsb_o both @c12; PT_WAIT@c13; end_associate_o never pulses.
//  - 3 AD blocks (last on 3rd) -> three 6-cycle runs with round_o 6..11; en_xor_lsb_o only on the 3rd run's last cycle; blk_cnt_o=3.
//  - 2 PT blocks (last on 2nd) -> one PT_RUN, then FINAL 12 cycles; 2 cipher_valid_o pulses; en_tag_o then end_o next cycle.
//  - ROUNDS_A=8, ROUNDS_B=4 -> INIT round_o 4..11, AD round_o 8..11; data_valid_i during RUN ignored (blk_cnt_o unchanged).

Source files
------------

// File: rtl/ascon_fsm_param.sv
// ---------------------------------------------------------------------------
// ascon_fsm_param
//
// Control FSM for an ASCON-128 AEAD datapath. The 320-bit state register
// lives outside this block. This FSM sequences the permutation rounds and
// raises the load, XOR and capture enables for the datapath.
//
// Supported traffic:
//   - Any number of associated-data blocks, including none.
//   - Any number of plaintext blocks.
//   - Blocks arrive on a valid/ready/last handshake.
//
// Round counts are parameters. The same block therefore serves full
// ASCON-128 (12/6) and reduced-round test builds.
//
// Optional feature (macro ASCON_DECRYPT_EN):
//   - Adds input decrypt_i, sampled together with start_i.
//   - Adds output en_replace_o.
//   - In a decrypt run, the first cycle of PT_RUN and of FINAL raises
//     en_replace_o instead of en_xor_data_o: the rate is overwritten by
//     the ciphertext rather than XORed.
//   - Without the macro the block is encrypt-only.
//
// Parameters:
//   ROUNDS_A  rounds of p^a (init, finalisation), 1..12
//   ROUNDS_B  rounds of p^b (AD and non-last PT blocks), 1..ROUNDS_A
//   BLK_W     width of the accepted-block counter
//
// Ports:
//   clock_i            single clock, rising edge
//   reset_i            synchronous, active-high; overrides everything
//   start_i            start request, sampled only in IDLE
//   ad_present_i       sampled with start_i; 0 = empty associated data
//   data_valid_i       a data block is offered
//   last_i             with data_valid_i: last block of the current phase
//   ready_o            FSM can accept a block (AD_WAIT / PT_WAIT only)
//   round_o            round-constant index for the permutation
//   init_state_o       load IV||K||N into the state register
//   en_reg_state_o     state register update enable
//   en_xor_data_o      XOR data block into the rate before the round
//   en_xor_begin_key_o XOR 0^64||K before the round
//   en_xor_end_key_o   XOR 0*||K after the round
//   en_xor_lsb_o       XOR the domain-separation bit after the round
//   en_cipher_o        capture the ciphertext register
//   cipher_valid_o     ciphertext register valid, one cycle after en_cipher_o
//   en_tag_o           capture the tag register
//   end_init_o         pulse: initialisation finished
//   end_associate_o    pulse: associated-data phase finished
//   end_o              pulse: tag valid
//   blk_cnt_o          blocks accepted since start, saturating
// ---------------------------------------------------------------------------
module ascon_fsm_param #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int BLK_W    = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             ad_present_i,
  input  logic             data_valid_i,
  input  logic             last_i,
`ifdef ASCON_DECRYPT_EN
  input  logic             decrypt_i,
  output logic             en_replace_o,
`endif
  output logic             ready_o,
  output logic [3:0]       round_o,
  output logic             init_state_o,
  output logic             en_reg_state_o,
  output logic             en_xor_data_o,
  output logic             en_xor_begin_key_o,
  output logic             en_xor_end_key_o,
  output logic             en_xor_lsb_o,
  output logic             en_cipher_o,
  output logic             cipher_valid_o,
  output logic             en_tag_o,
  output logic             end_init_o,
  output logic             end_associate_o,
  output logic             end_o,
  output logic [BLK_W-1:0] blk_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    AD_WAIT = 3'd2,
    AD_RUN  = 3'd3,
    PT_WAIT = 3'd4,
    PT_RUN  = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Round constants always end at index 11. A reduced-round permutation
  // therefore starts part way through the constant table.
  localparam logic [3:0]       BASE_A  = 4'(12 - ROUNDS_A);
  localparam logic [3:0]       BASE_B  = 4'(12 - ROUNDS_B);
  localparam logic [3:0]       LAST_A  = 4'(ROUNDS_A - 1);
  localparam logic [3:0]       LAST_B  = 4'(ROUNDS_B - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = '1;

  state_t           state, state_nxt;
  logic [3:0]       rnd_cnt, rnd_cnt_nxt;
  logic             ad_present_q;
  logic             last_q;
  logic             accept;
  logic             ad_xor;
  logic             pt_load;
  logic             end_init_nxt, end_assoc_nxt;
  logic             end_init_p1, end_assoc_p1, cipher_valid_p1;
  logic [BLK_W-1:0] blk_cnt;
`ifdef ASCON_DECRYPT_EN
  logic             decrypt_q;
`endif

  // Next-state and Moore outputs. Every output depends only on the state
  // and the round counter, never combinationally on an input.
  always_comb begin
    state_nxt          = state;
    rnd_cnt_nxt        = 4'd0;
    ready_o            = 1'b0;
    round_o            = 4'd0;
    init_state_o       = 1'b0;
    en_reg_state_o     = 1'b0;
    en_xor_begin_key_o = 1'b0;
    en_xor_end_key_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_cipher_o        = 1'b0;
    en_tag_o           = 1'b0;
    end_o              = 1'b0;
    end_init_nxt       = 1'b0;
    end_assoc_nxt      = 1'b0;
    accept             = 1'b0;
    ad_xor             = 1'b0;
    pt_load            = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = INIT;
      end

      INIT: begin
        round_o        = BASE_A + rnd_cnt;
        en_reg_state_o = 1'b1;
        init_state_o   = (rnd_cnt == 4'd0);
        if (rnd_cnt == LAST_A) begin
          en_xor_end_key_o = 1'b1;
          // With no AD, the domain-separation bit is applied here,
          // because no AD run follows to carry it.
          en_xor_lsb_o     = ~ad_present_q;
          end_init_nxt     = 1'b1;
          state_nxt        = ad_present_q ? AD_WAIT : PT_WAIT;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end

      AD_WAIT: begin
        ready_o = 1'b1;
        accept  = data_valid_i;
        if (accept) state_nxt = AD_RUN;
      end

      AD_RUN: begin
        round_o        = BASE_B + rnd_cnt;
        en_reg_state_o = 1'b1;
        ad_xor         = (rnd_cnt == 4'd0);
        if (rnd_cnt == LAST_B) begin
          if (last_q) begin
            en_xor_lsb_o  = 1'b1;
            end_assoc_nxt = 1'b1;
            state_nxt     = PT_WAIT;
          end else begin
            state_nxt     = AD_WAIT;
          end
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end

      PT_WAIT: begin
        ready_o = 1'b1;
        accept  = data_valid_i;
        if (accept) state_nxt = last_i ? FINAL : PT_RUN;
      end

      PT_RUN: begin
        round_o        = BASE_B + rnd_cnt;
        en_reg_state_o = 1'b1;
        pt_load        = (rnd_cnt == 4'd0);
        en_cipher_o    = (rnd_cnt == 4'd0);
        if (rnd_cnt == LAST_B) state_nxt = PT_WAIT;
        else                   rnd_cnt_nxt = rnd_cnt + 4'd1;
      end

      FINAL: begin
        round_o            = BASE_A + rnd_cnt;
        en_reg_state_o     = 1'b1;
        pt_load            = (rnd_cnt == 4'd0);
        en_cipher_o        = (rnd_cnt == 4'd0);
        en_xor_begin_key_o = (rnd_cnt == 4'd0);
        if (rnd_cnt == LAST_A) begin
          en_xor_end_key_o = 1'b1;
          en_tag_o         = 1'b1;
          state_nxt        = DONE;
        end else begin
          rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
      end

      DONE: begin
        end_o     = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

`ifdef ASCON_DECRYPT_EN
    // Decrypt overwrites the rate with ciphertext instead of XORing
    // plaintext. AD absorption is the same in both directions.
    en_xor_data_o = ad_xor | (pt_load & ~decrypt_q);
    en_replace_o  = pt_load & decrypt_q;
`else
    en_xor_data_o = ad_xor | pt_load;
`endif
  end

  // ---- stage p0 -> p1: state, counters, latched modes, delayed pulses ----
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      rnd_cnt         <= 4'd0;
      ad_present_q    <= 1'b0;
      last_q          <= 1'b0;
      blk_cnt         <= '0;
      end_init_p1     <= 1'b0;
      end_assoc_p1    <= 1'b0;
      cipher_valid_p1 <= 1'b0;
`ifdef ASCON_DECRYPT_EN
      decrypt_q       <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      rnd_cnt         <= rnd_cnt_nxt;
      end_init_p1     <= end_init_nxt;
      end_assoc_p1    <= end_assoc_nxt;
      cipher_valid_p1 <= en_cipher_o;
      if (state == IDLE && start_i) begin
        ad_present_q <= ad_present_i;
        blk_cnt      <= '0;
`ifdef ASCON_DECRYPT_EN
        decrypt_q    <= decrypt_i;
`endif
      end
      if (accept) begin
        if (blk_cnt != BLK_MAX) blk_cnt <= blk_cnt + BLK_W'(1);
        // Only an AD run needs to remember "last". A last PT block is
        // routed straight to FINAL at accept time.
        if (state == AD_WAIT) last_q <= last_i;
      end
    end
  end

  assign end_init_o      = end_init_p1;
  assign end_associate_o = end_assoc_p1;
  assign cipher_valid_o  = cipher_valid_p1;
  assign blk_cnt_o       = blk_cnt;

endmodule

// File: tb/tb_ascon_fsm_param.sv
// ---------------------------------------------------------------------------
// Bench for ascon_fsm_param.
//
// Two instances are used:
//   - default rounds (12/6);
//   - reduced rounds (8/4).
//
// For each scenario, a schedule builder lays out the whole message as a
// timeline of cycle numbers: init rounds, wait/accept points, run lengths,
// finalisation. From that timeline it fills an expected-output table and
// the per-cycle input table. A single compare process checks the selected
// instance against the table on every falling edge. Literal spot checks
// then pin selected points of the timeline.
// ---------------------------------------------------------------------------
module tb_ascon_fsm_param;

  localparam int MAXC = 2048;

  typedef struct packed {
    logic       ready;
    logic [3:0] round;
    logic       init_state, en_reg, xor_data, begin_key, end_key, lsb;
    logic       cipher, cvalid, tag, end_init, end_assoc, end_o;
    logic [7:0] blk;
  } ov_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic st  [2];
  logic adp [2];
  logic dv  [2];
  logic la  [2];

  logic [3:0] r0_round, r1_round;
  logic [7:0] r0_blk, r1_blk;
  logic r0_ready, r0_init, r0_reg, r0_xd, r0_bk, r0_ek, r0_lsb, r0_ci, r0_cv, r0_tag, r0_ei, r0_ea, r0_end;
  logic r1_ready, r1_init, r1_reg, r1_xd, r1_bk, r1_ek, r1_lsb, r1_ci, r1_cv, r1_tag, r1_ei, r1_ea, r1_end;
`ifdef ASCON_DECRYPT_EN
  logic rep0, rep1;
`endif

  ov_t act0, act1;
  assign act0 = {r0_ready, r0_round, r0_init, r0_reg, r0_xd, r0_bk, r0_ek, r0_lsb,
                 r0_ci, r0_cv, r0_tag, r0_ei, r0_ea, r0_end, r0_blk};
  assign act1 = {r1_ready, r1_round, r1_init, r1_reg, r1_xd, r1_bk, r1_ek, r1_lsb,
                 r1_ci, r1_cv, r1_tag, r1_ei, r1_ea, r1_end, r1_blk};

  ascon_fsm_param dut0 (
    .clock_i(clk), .reset_i(rst[0]), .start_i(st[0]), .ad_present_i(adp[0]),
    .data_valid_i(dv[0]), .last_i(la[0]),
`ifdef ASCON_DECRYPT_EN
    .decrypt_i(1'b0), .en_replace_o(rep0),
`endif
    .ready_o(r0_ready), .round_o(r0_round), .init_state_o(r0_init),
    .en_reg_state_o(r0_reg), .en_xor_data_o(r0_xd), .en_xor_begin_key_o(r0_bk),
    .en_xor_end_key_o(r0_ek), .en_xor_lsb_o(r0_lsb), .en_cipher_o(r0_ci),
    .cipher_valid_o(r0_cv), .en_tag_o(r0_tag), .end_init_o(r0_ei),
    .end_associate_o(r0_ea), .end_o(r0_end), .blk_cnt_o(r0_blk));

  ascon_fsm_param #(.ROUNDS_A(8), .ROUNDS_B(4), .BLK_W(8)) dut1 (
    .clock_i(clk), .reset_i(rst[1]), .start_i(st[1]), .ad_present_i(adp[1]),
    .data_valid_i(dv[1]), .last_i(la[1]),
`ifdef ASCON_DECRYPT_EN
    .decrypt_i(1'b0), .en_replace_o(rep1),
`endif
    .ready_o(r1_ready), .round_o(r1_round), .init_state_o(r1_init),
    .en_reg_state_o(r1_reg), .en_xor_data_o(r1_xd), .en_xor_begin_key_o(r1_bk),
    .en_xor_end_key_o(r1_ek), .en_xor_lsb_o(r1_lsb), .en_cipher_o(r1_ci),
    .cipher_valid_o(r1_cv), .en_tag_o(r1_tag), .end_init_o(r1_ei),
    .end_associate_o(r1_ea), .end_o(r1_end), .blk_cnt_o(r1_blk));

  ov_t ex      [MAXC];
  ov_t act_log [MAXC];
  bit  st_a    [MAXC];
  bit  dv_a    [MAXC];
  bit  la_a    [MAXC];
  int  acc_q   [$];
  int  blk_last [2];

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  sel   = 0;
  bit  chk_on = 1'b0;
  ov_t cmp_a;

  // Single compare process: the selected instance against the timeline.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_a = (sel == 1) ? act1 : act0;
      act_log[cyc] = cmp_a;
      n_vec++;
      if (cmp_a !== ex[cyc]) begin
        n_bad++;
        $display("FAIL cycle_%0d inst%0d: got %h want %h", cyc, sel, cmp_a, ex[cyc]);
      end
    end
  end

  task automatic pin(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic int cnt_pulse(input int which, input int len);
    int n;
    n = 0;
    for (int x = 0; x < len; x++) begin
      case (which)
        0: n += int'(act_log[x].cvalid);
        1: n += int'(act_log[x].end_assoc);
        2: n += int'(act_log[x].end_o);
        default: n += int'(act_log[x].tag);
      endcase
    end
    return n;
  endfunction

  // Build the timeline for one message, then drive it and let the compare
  // process check it. Arguments:
  //   s      instance select
  //   ra/rb  its round counts
  //   ap     AD present
  //   nad    number of AD blocks
  //   npt    number of PT blocks
  //   gb     base for the wait cycles inserted before each block
  //   noise  also offer blocks / starts where they must be ignored
  task automatic run_scn(input int s, input int ra, input int rb, input bit ap,
                         input int nad, input int npt, input int gb,
                         input bit noise, output int len);
    int c, acc, r, g, cnt, t0;
    bit lastb;
    t0 = 1;
    acc_q.delete();
    for (int x = 0; x < MAXC; x++) begin
      ex[x] = '0; act_log[x] = '0; st_a[x] = 1'b0; dv_a[x] = 1'b0; la_a[x] = 1'b0;
    end
    st_a[t0] = 1'b1;
    c = t0 + 1;
    for (int k = 0; k < ra; k++) begin
      ex[c+k].round  = 4'(12 - ra + k);
      ex[c+k].en_reg = 1'b1;
    end
    ex[c].init_state    = 1'b1;
    ex[c+ra-1].end_key  = 1'b1;
    ex[c+ra-1].lsb      = !ap;
    if (noise) begin st_a[c+2] = 1'b1; dv_a[c+1] = 1'b1; end
    c += ra;
    ex[c].end_init = 1'b1;
    if (ap) begin
      for (int i = 0; i < nad; i++) begin
        g = (gb + i) % 3;
        lastb = (i == nad - 1);
        for (int w = 0; w <= g; w++) begin
          ex[c+w].ready = 1'b1;
          if (noise && w < g) la_a[c+w] = 1'b1;
        end
        acc = c + g; dv_a[acc] = 1'b1; la_a[acc] = lastb; acc_q.push_back(acc);
        r = acc + 1;
        for (int k = 0; k < rb; k++) begin
          ex[r+k].round  = 4'(12 - rb + k);
          ex[r+k].en_reg = 1'b1;
        end
        ex[r].xor_data = 1'b1;
        if (lastb) ex[r+rb-1].lsb = 1'b1;
        if (noise) begin dv_a[r+1] = 1'b1; la_a[r+1] = 1'b1; end
        c = r + rb;
        if (lastb) ex[c].end_assoc = 1'b1;
      end
    end
    for (int i = 0; i < npt; i++) begin
      g = (gb + i) % 3;
      lastb = (i == npt - 1);
      for (int w = 0; w <= g; w++) begin
        ex[c+w].ready = 1'b1;
        if (noise && w < g) la_a[c+w] = 1'b1;
      end
      acc = c + g; dv_a[acc] = 1'b1; la_a[acc] = lastb; acc_q.push_back(acc);
      r = acc + 1;
      ex[r].xor_data = 1'b1; ex[r].cipher = 1'b1; ex[r+1].cvalid = 1'b1;
      if (!lastb) begin
        for (int k = 0; k < rb; k++) begin
          ex[r+k].round  = 4'(12 - rb + k);
          ex[r+k].en_reg = 1'b1;
        end
        if (noise) dv_a[r+2] = 1'b1;
        c = r + rb;
      end else begin
        for (int k = 0; k < ra; k++) begin
          ex[r+k].round  = 4'(12 - ra + k);
          ex[r+k].en_reg = 1'b1;
        end
        ex[r].begin_key = 1'b1;
        ex[r+ra-1].end_key = 1'b1; ex[r+ra-1].tag = 1'b1;
        c = r + ra;
        ex[c].end_o = 1'b1;
        if (noise) st_a[c] = 1'b1;
      end
    end
    len = c + 3;
    cnt = 0;
    for (int x = 0; x < len; x++) begin
      if (x <= t0) ex[x].blk = 8'(blk_last[s]);
      else begin
        while (cnt < acc_q.size() && acc_q[cnt] < x) cnt++;
        ex[x].blk = 8'((cnt > 255) ? 255 : cnt);
      end
    end
    blk_last[s] = int'(ex[len-1].blk);

    sel = s;
    adp[s] = ap;
    for (int n = 0; n < len; n++) begin
      cyc = n;
      st[s] = st_a[n]; dv[s] = dv_a[n]; la[s] = la_a[n];
      chk_on = 1'b1;
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
    st[s] = 1'b0; dv[s] = 1'b0; la[s] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; adp[i] = 1'b0; dv[i] = 1'b0; la[i] = 1'b0;
      blk_last[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    pin("reset_dut0", int'(act0), 0);
    pin("reset_dut1", int'(act1), 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // 12/6, three AD blocks and two PT blocks, with ignored traffic
    run_scn(0, 12, 6, 1'b1, 3, 2, 0, 1'b1, len);
    pin("s1_init_first_round", int'(act_log[2].round), 0);
    pin("s1_init_state",       int'(act_log[2].init_state), 1);
    pin("s1_init_last_round",  int'(act_log[13].round), 11);
    pin("s1_init_end_key",     int'(act_log[13].end_key), 1);
    pin("s1_init_no_lsb",      int'(act_log[13].lsb), 0);
    pin("s1_end_init",         int'(act_log[14].end_init), 1);
    pin("s1_cipher_valid_cnt", cnt_pulse(0, len), 2);
    pin("s1_end_assoc_cnt",    cnt_pulse(1, len), 1);
    pin("s1_end_cnt",          cnt_pulse(2, len), 1);
    pin("s1_blk_final",        int'(act_log[len-1].blk), 5);

    // 12/6, empty AD, a single (last) PT block
    run_scn(0, 12, 6, 1'b0, 0, 1, 1, 1'b0, len);
    pin("s2_init_lsb",         int'(act_log[13].lsb), 1);
    pin("s2_init_end_key",     int'(act_log[13].end_key), 1);
    pin("s2_pt_wait_ready",    int'(act_log[14].ready), 1);
    pin("s2_end_assoc_cnt",    cnt_pulse(1, len), 0);
    pin("s2_blk_final",        int'(act_log[len-1].blk), 1);

    // 12/6, one AD block and four PT blocks, longer gaps
    run_scn(0, 12, 6, 1'b1, 1, 4, 2, 1'b1, len);
    pin("s3_cipher_valid_cnt", cnt_pulse(0, len), 4);
    pin("s3_tag_cnt",          cnt_pulse(3, len), 1);
    pin("s3_blk_final",        int'(act_log[len-1].blk), 5);

    // Reset in the middle of INIT, while round_o is 5
    sel = 0;
    st[0] = 1'b1; adp[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    n = 0;
    while (r0_round !== 4'd5 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    pin("rst_wait_round5_timeout", int'(n >= 40), 0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    pin("rst_all_outputs_zero", int'(act0), 0);
    pin("rst_ready_low",        int'(r0_ready), 0);
    @(posedge clk); #1;
    pin("rst_stays_idle",       int'(act0), 0);
    blk_last[0] = 0;

    // Normal traffic after the mid-run reset
    run_scn(0, 12, 6, 1'b1, 2, 1, 1, 1'b0, len);

    // 8/4, two AD blocks and three PT blocks, with ignored traffic
    run_scn(1, 8, 4, 1'b1, 2, 3, 0, 1'b1, len);
    pin("s4_init_first_round", int'(act_log[2].round), 4);
    pin("s4_init_last_round",  int'(act_log[9].round), 11);
    pin("s4_ad_first_round",   int'(act_log[11].round), 8);
    pin("s4_ad_xor_data",      int'(act_log[11].xor_data), 1);
    pin("s4_ad_last_round",    int'(act_log[14].round), 11);
    pin("s4_blk_ignores_run",  int'(act_log[14].blk), 1);

    // 8/4, enough AD blocks to saturate the 8-bit block counter
    run_scn(1, 8, 4, 1'b1, 258, 1, 0, 1'b0, len);
    pin("s5_blk_saturated",    int'(act_log[len-1].blk), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
